// File: rtl/command_frame_decoder.sv
// Byte-stream frame decoder: SYNC, ADDR, DATA, XOR checksum -> single-cycle register write.
// Optional CMD_DECODER_ACK_EN adds an ack byte channel (5A good, E1 checksum, E2 timeout).
module command_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [DATA_WIDTH-1:0] cmd_data_o,
  output logic                  cmd_valid_o,
  output logic [15:0]           frame_count_o,
  output logic [15:0]           error_count_o,
`ifdef CMD_DECODER_ACK_EN
  output logic [7:0]            ack_byte_o,
  output logic                  ack_valid_o,
  input  logic                  ack_ready_i,
`endif
  output logic                  busy_o
);

  localparam int unsigned ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned IDX_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_HUNT  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_ISSUE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_sr_q, addr_sr_d, cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] data_sr_q, data_sr_d, cmd_data_q, cmd_data_d;
  logic [15:0]           frame_cnt_q, err_cnt_q;
  logic                  accept, in_frame, timeout, frame_inc, err_inc, ack_block;

  assign accept   = byte_valid_i && byte_ready_o;
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign timeout  = in_frame && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    addr_sr_d  = addr_sr_q;
    data_sr_d  = data_sr_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;
    if (in_frame) tmo_d = accept ? '0 : tmo_q + 1'b1;
    // A byte arriving on the timeout cycle is dropped, never re-examined as SYNC.
    if (timeout) begin
      state_d = ST_HUNT;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (accept && (byte_i == SYNC_BYTE)) begin
            state_d = ST_ADDR;
            idx_d   = '0;
            csum_d  = '0;
            tmo_d   = '0;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            addr_sr_d = ADDR_WIDTH'({addr_sr_q, byte_i});
            csum_d    = csum_q ^ byte_i;
            if (idx_q == ADDR_LAST) begin
              idx_d   = '0;
              state_d = ST_DATA;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            data_sr_d = DATA_WIDTH'({data_sr_q, byte_i});
            csum_d    = csum_q ^ byte_i;
            if (idx_q == DATA_LAST) begin
              idx_d   = '0;
              state_d = ST_CSUM;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        ST_CSUM: begin
          if (accept) begin
            if (byte_i == csum_q) begin
              state_d    = ST_ISSUE;
              frame_inc  = 1'b1;
              cmd_addr_d = addr_sr_q;
              cmd_data_d = data_sr_q;
            end else begin
              state_d = ST_HUNT;
              err_inc = 1'b1;
            end
          end
        end
        ST_ISSUE: state_d = ST_HUNT;
        default:  state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_HUNT;
      idx_q       <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      addr_sr_q  <= addr_sr_d;
      data_sr_q  <= data_sr_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      if (frame_inc && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_inc && (err_cnt_q != 16'hFFFF))     err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

`ifdef CMD_DECODER_ACK_EN
  logic       ack_pending_q;
  logic [7:0] ack_byte_q, ack_code;

  always_comb begin
    ack_code = 8'h5A;
    if (timeout)      ack_code = 8'hE2;
    else if (err_inc) ack_code = 8'hE1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_pending_q <= 1'b0;
      ack_byte_q    <= '0;
    end else if (frame_inc || err_inc) begin
      ack_pending_q <= 1'b1;
      ack_byte_q    <= ack_code;
    end else if (ack_pending_q && ack_ready_i) begin
      ack_pending_q <= 1'b0;
    end
  end

  // Only HUNT is gated, so an in-flight frame and its ISSUE cycle are never stalled.
  assign ack_block   = ack_pending_q && (state_q == ST_HUNT);
  assign ack_byte_o  = ack_byte_q;
  assign ack_valid_o = ack_pending_q;
`else
  assign ack_block = 1'b0;
`endif

  assign byte_ready_o  = (state_q != ST_ISSUE) && !ack_block;
  assign cmd_valid_o   = (state_q == ST_ISSUE);
  assign cmd_addr_o    = cmd_addr_q;
  assign cmd_data_o    = cmd_data_q;
  assign frame_count_o = frame_cnt_q;
  assign error_count_o = err_cnt_q;
  assign busy_o        = (state_q != ST_HUNT);

endmodule

// File: tb/tb_command_frame_decoder.sv
// Self-checking bench for command_frame_decoder; write strobes are checked against a scoreboard.
module tb_command_frame_decoder;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic [15:0] cmd_addr_o;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic [15:0] frame_count_o;
  logic [15:0] error_count_o;
  logic        busy_o;
`ifdef CMD_DECODER_ACK_EN
  logic [7:0]  ack_byte_o;
  logic        ack_valid_o;
  logic        ack_ready_i = 1'b1;
`endif

  int checks = 0;
  int fails = 0;
  int strobes = 0;
  logic [47:0] sb[$];

  localparam logic [63:0] GOOD   = 64'hA5_0050_00001234_76;
  localparam logic [63:0] BAD    = 64'hA5_0050_00001234_77;
  localparam logic [63:0] SECOND = 64'hA5_00A0_00003C00_9C;
  localparam logic [63:0] ALLSYN = 64'hA5_A5A5_A5A5A5A5_00;

  command_frame_decoder #(
    .SYNC_BYTE     (8'hA5),
    .ADDR_WIDTH    (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .cmd_addr_o   (cmd_addr_o),
    .cmd_data_o   (cmd_data_o),
    .cmd_valid_o  (cmd_valid_o),
    .frame_count_o(frame_count_o),
    .error_count_o(error_count_o),
`ifdef CMD_DECODER_ACK_EN
    .ack_byte_o   (ack_byte_o),
    .ack_valid_o  (ack_valid_o),
    .ack_ready_i  (ack_ready_i),
`endif
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard consumer: every strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    if (rst_n_i && cmd_valid_o) begin
      logic [47:0] exp_w;
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe got addr=%h data=%h, required no strobe",
                 cmd_addr_o, cmd_data_o);
      end else begin
        exp_w = sb.pop_front();
        if ({cmd_addr_o, cmd_data_o} !== exp_w) begin
          fails++;
          $display("FAIL strobe_value got %h_%h, required %h_%h",
                   cmd_addr_o, cmd_data_o, exp_w[47:32], exp_w[31:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic do_reset();
    byte_valid_i = 1'b0;
    rst_n_i = 1'b0;
    idle(2);
    sb.delete();
    strobes = 0;
    rst_n_i = 1'b1;
    idle(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) begin
      checks++;
      fails++;
      $display("FAIL byte_accept_timeout got ready=%b, required ready=1 within 50 cycles",
               byte_ready_o);
    end
    @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [63:0] f);
    logic [7:0] cs;
    cs = f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
    if (cs == f[7:0]) sb.push_back(f[55:8]);
    for (int i = 7; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic test_reset();
    byte_valid_i = 1'b0;
    rst_n_i = 1'b0;
    idle(2);
    checks++;
    if ({byte_ready_o, cmd_valid_o, busy_o} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags got ready/valid/busy=%b, required 100",
               {byte_ready_o, cmd_valid_o, busy_o});
    end
    checks++;
    if ({cmd_addr_o, cmd_data_o, frame_count_o, error_count_o} !== 80'd0) begin
      fails++;
      $display("FAIL reset_values got %h %h %h %h, required all zero",
               cmd_addr_o, cmd_data_o, frame_count_o, error_count_o);
    end
    rst_n_i = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame();
    do_reset();
    send_frame(GOOD);
    checks++;
    if (cmd_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL good_pulse_rise got %b, required 1", cmd_valid_o);
    end
    byte_valid_i = 1'b0;
    idle(1);
    checks++;
    if (cmd_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL good_pulse_fall got %b, required 0", cmd_valid_o);
    end
    checks++;
    if ({cmd_addr_o, cmd_data_o} !== 48'h0050_00001234) begin
      fails++;
      $display("FAIL good_hold got %h_%h, required 0050_00001234", cmd_addr_o, cmd_data_o);
    end
    idle(3);
    checks++;
    if ({frame_count_o, error_count_o, strobes[15:0], busy_o} !== {16'd1, 16'd0, 16'd1, 1'b0}) begin
      fails++;
      $display("FAIL good_counts got frames=%0d errors=%0d strobes=%0d busy=%b, required 1 0 1 0",
               frame_count_o, error_count_o, strobes, busy_o);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    send_frame(BAD);
    checks++;
    if ({cmd_valid_o, busy_o, error_count_o} !== {1'b0, 1'b0, 16'd1}) begin
      fails++;
      $display("FAIL bad_csum got valid=%b busy=%b errors=%0d, required 0 0 1",
               cmd_valid_o, busy_o, error_count_o);
    end
    send_frame(GOOD);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, error_count_o, strobes[15:0]} !== {16'd1, 16'd1, 16'd1}) begin
      fails++;
      $display("FAIL bad_recovery got frames=%0d errors=%0d strobes=%0d, required 1 1 1",
               frame_count_o, error_count_o, strobes);
    end
  endtask

  task automatic test_garbage();
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    checks++;
    if (busy_o !== 1'b0) begin
      fails++;
      $display("FAIL garbage_busy got %b, required 0", busy_o);
    end
    send_frame(GOOD);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, error_count_o, strobes[15:0]} !== {16'd1, 16'd0, 16'd1}) begin
      fails++;
      $display("FAIL garbage_counts got frames=%0d errors=%0d strobes=%0d, required 1 0 1",
               frame_count_o, error_count_o, strobes);
    end
  endtask

  task automatic test_sync_in_payload();
    do_reset();
    send_frame(ALLSYN);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({cmd_addr_o, cmd_data_o, frame_count_o} !== {48'hA5A5_A5A5A5A5, 16'd1}) begin
      fails++;
      $display("FAIL sync_payload got %h_%h frames=%0d, required a5a5_a5a5a5a5 1",
               cmd_addr_o, cmd_data_o, frame_count_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    byte_valid_i = 1'b0;
    idle(10);
    checks++;
    if ({busy_o, error_count_o} !== {1'b1, 16'd0}) begin
      fails++;
      $display("FAIL timeout_early got busy=%b errors=%0d, required 1 0", busy_o, error_count_o);
    end
    idle(10);
    checks++;
    if ({busy_o, error_count_o} !== {1'b0, 16'd1}) begin
      fails++;
      $display("FAIL timeout_fire got busy=%b errors=%0d, required 0 1", busy_o, error_count_o);
    end
    send_frame(GOOD);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, error_count_o, strobes[15:0]} !== {16'd1, 16'd1, 16'd1}) begin
      fails++;
      $display("FAIL timeout_recovery got frames=%0d errors=%0d strobes=%0d, required 1 1 1",
               frame_count_o, error_count_o, strobes);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(GOOD);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h50);
    byte_valid_i = 1'b0;
    rst_n_i = 1'b0;
    idle(1);
    checks++;
    if ({frame_count_o, error_count_o, cmd_valid_o, busy_o} !== 34'd0) begin
      fails++;
      $display("FAIL reset_mid got frames=%0d errors=%0d valid=%b busy=%b, required 0 0 0 0",
               frame_count_o, error_count_o, cmd_valid_o, busy_o);
    end
    sb.delete();
    strobes = 0;
    rst_n_i = 1'b1;
    idle(1);
    send_frame(SECOND);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, strobes[15:0]} !== {16'd1, 16'd1}) begin
      fails++;
      $display("FAIL reset_mid_recovery got frames=%0d strobes=%0d, required 1 1",
               frame_count_o, strobes);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(GOOD);
    send_frame(SECOND);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, error_count_o, strobes[15:0]} !== {16'd2, 16'd0, 16'd2}) begin
      fails++;
      $display("FAIL b2b_counts got frames=%0d errors=%0d strobes=%0d, required 2 0 2",
               frame_count_o, error_count_o, strobes);
    end
    checks++;
    if ({cmd_addr_o, cmd_data_o, sb.size() == 0} !== {48'h00A0_00003C00, 1'b1}) begin
      fails++;
      $display("FAIL b2b_last got %h_%h pending=%0d, required 00a0_00003c00 0",
               cmd_addr_o, cmd_data_o, sb.size());
    end
  endtask

`ifdef CMD_DECODER_ACK_EN
  task automatic test_ack();
    ack_ready_i = 1'b0;
    do_reset();
    send_frame(GOOD);
    byte_valid_i = 1'b0;
    idle(2);
    checks++;
    if ({ack_valid_o, ack_byte_o, byte_ready_o} !== {1'b1, 8'h5A, 1'b0}) begin
      fails++;
      $display("FAIL ack_hold got valid=%b byte=%h ready=%b, required 1 5a 0",
               ack_valid_o, ack_byte_o, byte_ready_o);
    end
    byte_i = 8'hA5;
    byte_valid_i = 1'b1;
    idle(4);
    checks++;
    if ({busy_o, ack_byte_o} !== {1'b0, 8'h5A}) begin
      fails++;
      $display("FAIL ack_block got busy=%b byte=%h, required 0 5a", busy_o, ack_byte_o);
    end
    ack_ready_i = 1'b1;
    send_frame(SECOND);
    byte_valid_i = 1'b0;
    idle(3);
    checks++;
    if ({frame_count_o, strobes[15:0], ack_valid_o} !== {16'd2, 16'd2, 1'b0}) begin
      fails++;
      $display("FAIL ack_drain got frames=%0d strobes=%0d ack_valid=%b, required 2 2 0",
               frame_count_o, strobes, ack_valid_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_garbage();
    test_sync_in_payload();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
`ifdef CMD_DECODER_ACK_EN
    test_ack();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/command_frame_decoder.md
Name: command_frame_decoder

Overview:
- Upstream feeder of the register controller.
- Parses a byte stream from the host UART receiver into framed register writes (address, data, checksum).
- Emits one single-cycle addr/data/valid write per good frame; the top level wires these into the controller's command_interface.
- Rejects bad or stalled frames and counts them.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_WIDTH, 16, command address width; must be a multiple of 8.
- DATA_WIDTH, 32, command data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 100000, maximum idle clocks between bytes inside a frame; must be ≥2.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- byte_i  in  8  received byte.
- byte_valid_i  in  1  byte_i valid.
- byte_ready_o  out  1  decoder accepts byte this cycle.
- cmd_addr_o  out  ADDR_WIDTH  write address.
- cmd_data_o  out  DATA_WIDTH  write data.
- cmd_valid_o  out  1  single-cycle write strobe.
- frame_count_o  out  16  good frames, saturating.
- error_count_o  out  16  checksum + timeout errors, saturating.
- busy_o  out  1  state != HUNT.

Behaviour:
- Interface and reset:
  - Clock is clk_i; reset is rst_n_i, asynchronous, active-low.
  - Reset values: all outputs 0 except byte_ready_o=1; state HUNT.
  - Reset mid-frame discards the partial frame. No cmd_valid_o is issued for it.
- Byte handshake:
  - A byte is accepted on a clock edge where byte_valid_i && byte_ready_o.
  - byte_ready_o = 1 in every state except ISSUE (and see the optional feature).
- Frame format:
  - Fields in order: SYNC, ADDR (ADDR_WIDTH/8 bytes, MSB first), DATA (DATA_WIDTH/8 bytes, MSB first), CSUM.
  - CSUM = XOR of all ADDR and DATA bytes. SYNC is excluded.
- State machine:
  - HUNT:
    - Accepted byte == SYNC_BYTE → ADDR, with byte index and running checksum cleared.
    - Any other byte is discarded without counting as an error.
  - ADDR: shift each byte into an address shift register and XOR it into the checksum. After the last address byte → DATA.
  - DATA: same as ADDR for data bytes. After the last data byte → CSUM.
  - CSUM:
    - Byte == running checksum → ISSUE, and frame_count_o increments.
    - Otherwise → HUNT, and error_count_o increments.
  - ISSUE:
    - Lasts exactly one cycle.
    - cmd_valid_o = 1 and cmd_addr_o/cmd_data_o present the shifted values, then → HUNT.
- Latency:
  - CSUM byte accepted at edge N → cmd_valid_o high for the cycle after edge N, low after edge N+1.
  - A SYNC byte presented during ISSUE is not accepted; it is taken the following cycle in HUNT.
- Output holding: cmd_addr_o/cmd_data_o hold the last issued values between strobes. They are only updated on entry to ISSUE.
- Timeout:
  - A counter runs in ADDR/DATA/CSUM and clears on every accepted byte and on entry to ADDR.
  - Reaching TIMEOUT_CYCLES-1 → HUNT, error_count_o increments, partial frame dropped.
  - If a byte is accepted in the same cycle the timeout fires, the timeout wins and the byte is dropped, not re-examined as SYNC.
- Counters: both saturate at 16'hFFFF. Checksum error and timeout are mutually exclusive per frame.
- SYNC_BYTE inside payload or CSUM is ordinary data. There is no resync mid-frame except by timeout.

Optional Feature:
- Macro: CMD_DECODER_ACK_EN.
- Enabled — added ports:
  - ack_byte_o  out  8.
  - ack_valid_o  out  1.
  - ack_ready_i  in  1.
- Enabled — behaviour:
  - Good frame queues 8'h5A; checksum error queues 8'hE1; timeout queues 8'hE2.
  - The ack is held in one register until ack_valid_o && ack_ready_i.
  - While an ack is pending and the state is HUNT, byte_ready_o = 0, so no new frame starts until the ack drains.
  - A pending ack never blocks ISSUE.
- Disabled: the ports are absent and byte_ready_o follows the base rule only.

Test Plan:
- Good frame: A5 00 50 00 00 12 34 76, byte_valid_i held high → one cmd_valid_o pulse; addr=16'h0050, data=32'h00001234; frame_count=1, error_count=0; pulse falls one cycle after the CSUM edge.
- Bad checksum and recovery: same frame with CSUM 77 → no cmd_valid_o, error_count=1. Then the good frame → write issued, frame_count=1.
- Garbage before sync: 00 FF 12 then the good frame → exactly one write with the same values; error_count=0.
- Timeout with TIMEOUT_CYCLES=16: A5 00, then idle 16 cycles → busy_o=0, error_count=1. The next good frame is issued normally.
- Reset and back-to-back:
  - rst_n_i low after A5 00 50 → counters 0, no strobe; a full frame after release is decoded.
  - Two consecutive good frames (second: A5 00 A0 00 00 3C 00 9C) → two strobes, frame_count=2.
- With CMD_DECODER_ACK_EN:
  - Good frame with ack_ready_i low → ack_byte_o=5A held.
  - A following A5 is not accepted until ack_ready_i goes high.
